// File: rtl/csi_rx_lane_merge_pkg.sv
// Shared types for the CSI-2 receive lane merger: lane count default, byte/valid types, FSM states.
package csi_rx_lane_merge_pkg;

  localparam int NUM_LANE = 4;

  typedef logic [7:0]          lane_data_t;
  typedef logic [NUM_LANE-1:0] lane_vld_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    STREAM,
    DONE,
    ERR
  } merge_state_t;

endpackage

// File: rtl/csi_rx_skew_fifo.sv
// Per-lane skew FIFO: 8-bit x DEPTH, extra pointer MSB separates full from empty, synchronous flush.
module csi_rx_skew_fifo
  import csi_rx_lane_merge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       byte_clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  lane_data_t din,
  output lane_data_t dout,
  output logic       full,
  output logic       empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        wr_en, rd_en;
  lane_data_t  mem_q [DEPTH];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    wr_en    = push && (!full || pop) && !flush;
    rd_en    = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    dout = mem_q[rd_ptr_q[AW-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge byte_clock) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/csi_rx_lane_merge.sv
// Multi-lane deskew and word merger: one skew FIFO per lane, words released only when all active lanes hold data.
module csi_rx_lane_merge
  import csi_rx_lane_merge_pkg::*;
#(
  parameter int MAX_LANE   = NUM_LANE,
  parameter int SKEW_DEPTH = 4
) (
  input  logic                         byte_clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [$clog2(MAX_LANE+1)-1:0] num_lanes,
  input  logic                         wait_for_sync,
  input  logic                         packet_done,
  input  logic [MAX_LANE*8-1:0]        byte_in,
  input  logic [MAX_LANE-1:0]          byte_vld,
  output logic                         packet_done_out,
  output logic [MAX_LANE*8-1:0]        word_out,
  output logic                         word_vld,
  output logic                         skew_err,
  output logic                         cfg_err
);

  localparam int LCW = $clog2(MAX_LANE + 1);
  localparam int SCW = $clog2(SKEW_DEPTH) + 1;

  merge_state_t          state_q, state_d;
  logic [LCW-1:0]        lane_cnt_q, lane_cnt_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [SCW-1:0]        skew_cnt_q, skew_cnt_d;
  logic [MAX_LANE*8-1:0] word_q, word_d;
  logic                  word_vld_q, word_vld_d;

  logic [MAX_LANE-1:0]   lane_act, push, full, empty;
  logic [MAX_LANE*8-1:0] word_mask, fifo_dout;
  logic                  accept, all_ready, pop_all, overflow, skew_hit, flush;

  for (genvar gi = 0; gi < MAX_LANE; gi++) begin : g_lane
    csi_rx_skew_fifo #(.DEPTH(SKEW_DEPTH)) u_fifo (
      .byte_clock (byte_clock),
      .reset_n    (reset_n),
      .push       (push[gi]),
      .pop        (pop_all),
      .flush      (flush),
      .din        (byte_in[8*gi +: 8]),
      .dout       (fifo_dout[8*gi +: 8]),
      .full       (full[gi]),
      .empty      (empty[gi])
    );
  end

  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A full lane may still take a byte in the cycle it is popped; only an unpopped full push overflows.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (wait_for_sync) state_d = ALIGN;
        ALIGN:   if (all_ready) state_d = STREAM;
                 else if (overflow || skew_hit) state_d = ERR;
        STREAM:  if (overflow) state_d = ERR;
                 else if (packet_done) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    lane_act  = '0;
    word_mask = '0;
    for (int i = 0; i < MAX_LANE; i++) begin
      lane_act[i]          = (i < int'(lane_cnt_q));
      word_mask[8*i +: 8]  = {8{lane_act[i]}};
    end
    accept          = enable && (state_q == ALIGN || state_q == STREAM);
    push            = byte_vld & lane_act & {MAX_LANE{accept}};
    all_ready       = &(~empty | ~lane_act);
    pop_all         = accept && all_ready;
    overflow        = !pop_all && |(push & full);
    skew_hit        = (skew_cnt_q == SCW'(SKEW_DEPTH));
    flush           = !enable || (state_q inside {IDLE, DONE, ERR});
    skew_err        = (state_q == ERR);
    packet_done_out = (state_q inside {DONE, ERR});
  end

  // Lane count is only re-latched in IDLE; illegal values fall back to full width.
  always_comb begin
    lane_cnt_d = lane_cnt_q;
    cfg_err_d  = cfg_err_q;
    if (state_q == IDLE) begin
      cfg_err_d  = (num_lanes == '0) || (int'(num_lanes) > MAX_LANE);
      lane_cnt_d = cfg_err_d ? LCW'(MAX_LANE) : num_lanes;
    end
    skew_cnt_d = '0;
    if (state_q == ALIGN && enable && (skew_cnt_q != '0 || |push))
      skew_cnt_d = skew_cnt_q + SCW'(1);
    word_vld_d = pop_all;
    word_d     = (pop_all ? fifo_dout : word_q) & word_mask;
  end

  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      lane_cnt_q <= LCW'(MAX_LANE);
      cfg_err_q  <= 1'b0;
      skew_cnt_q <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      cfg_err_q  <= cfg_err_d;
      skew_cnt_q <= skew_cnt_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
    end
  end

  assign word_out = word_q & word_mask;
  assign word_vld = word_vld_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_csi_rx_lane_merge.sv
// Randomised bench for csi_rx_lane_merge against a per-packet arithmetic model of the merged word stream.
module tb_csi_rx_lane_merge;

  localparam int MAX_LANE   = 4;
  localparam int SKEW_DEPTH = 4;
  localparam int LCW        = $clog2(MAX_LANE + 1);
  localparam int MAX_BYTES  = 16;

  logic                  byte_clock = 1'b0;
  logic                  reset_n;
  logic                  enable;
  logic [LCW-1:0]        num_lanes;
  logic                  wait_for_sync;
  logic                  packet_done;
  logic [MAX_LANE*8-1:0] byte_in;
  logic [MAX_LANE-1:0]   byte_vld;
  logic                  packet_done_out;
  logic [MAX_LANE*8-1:0] word_out;
  logic                  word_vld;
  logic                  skew_err;
  logic                  cfg_err;

  csi_rx_lane_merge #(.MAX_LANE(MAX_LANE), .SKEW_DEPTH(SKEW_DEPTH)) dut (
    .byte_clock      (byte_clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .num_lanes       (num_lanes),
    .wait_for_sync   (wait_for_sync),
    .packet_done     (packet_done),
    .byte_in         (byte_in),
    .byte_vld        (byte_vld),
    .packet_done_out (packet_done_out),
    .word_out        (word_out),
    .word_vld        (word_vld),
    .skew_err        (skew_err),
    .cfg_err         (cfg_err)
  );

  always #5 byte_clock = ~byte_clock;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] held_word;
  int          lane_delay [MAX_LANE];
  logic [7:0]  lane_data  [MAX_LANE][MAX_BYTES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge byte_clock);
    #1;
  endtask

  // Lane i sends n bytes on consecutive cycles starting at lane_delay[i] (cycle 0 = first ALIGN cycle).
  // Model: word k is every active lane's k-th byte, valid at cycle dmax+2+k; skew >= SKEW_DEPTH aborts.
  task automatic run_packet(input int nl, input int n, input int drop_in, input int rst_at,
                            input int first_byte);
    int          eff, dmin, dmax, len, drop_at, skew_pulses, pdo_pulses, skew_cyc, pdo_cyc;
    bit          err, stop;
    logic        exp_vld, exp_pdo, exp_cfg;
    logic [31:0] mask, exp_word;
    eff  = (nl == 0 || nl > MAX_LANE) ? MAX_LANE : nl;
    exp_cfg = (nl == 0 || nl > MAX_LANE);
    mask = '0;
    dmin = 1000;
    dmax = 0;
    for (int i = 0; i < eff; i++) begin
      mask[8*i +: 8] = 8'hFF;
      if (lane_delay[i] < dmin) dmin = lane_delay[i];
      if (lane_delay[i] > dmax) dmax = lane_delay[i];
    end
    for (int i = 0; i < MAX_LANE; i++)
      for (int k = 0; k < MAX_BYTES; k++)
        lane_data[i][k] = 8'($urandom);
    if (first_byte >= 0)
      for (int i = 0; i < MAX_LANE; i++) lane_data[i][0] = 8'(first_byte);
    err     = (dmax - dmin) >= SKEW_DEPTH;
    drop_at = err ? -1 : drop_in;
    len     = err ? 16 : dmax + n + 4;

    num_lanes     = LCW'(nl);
    enable        = 1'b1;
    wait_for_sync = 1'b1;
    byte_vld      = '0;
    packet_done   = 1'b0;
    tick();
    wait_for_sync = 1'b0;
    held_word     = held_word & mask;
    skew_pulses   = 0;
    pdo_pulses    = 0;
    skew_cyc      = -1;
    pdo_cyc       = -1;
    stop          = 1'b0;

    for (int c = 0; c < len && !stop; c++) begin
      for (int i = 0; i < MAX_LANE; i++) begin
        if (i < eff) begin
          byte_vld[i]      = (c >= lane_delay[i]) && (c < lane_delay[i] + n);
          byte_in[8*i +: 8] = 8'($urandom);
          if (byte_vld[i]) byte_in[8*i +: 8] = lane_data[i][c - lane_delay[i]];
        end else begin
          byte_vld[i]       = 1'($urandom);
          byte_in[8*i +: 8] = 8'($urandom);
        end
      end
      packet_done = !err && drop_at < 0 && c == dmax + n;
      if (drop_at >= 0 && c >= drop_at) enable = 1'b0;

      @(negedge byte_clock);
      exp_vld = !err && c >= dmax + 2 && c <= dmax + n + 1 && (drop_at < 0 || c <= drop_at);
      if (exp_vld) begin
        exp_word = '0;
        for (int i = 0; i < eff; i++) exp_word[8*i +: 8] = lane_data[i][c - dmax - 2];
        held_word = exp_word;
      end
      check($sformatf("word_vld nl%0d c%0d", nl, c), 32'(word_vld), 32'(exp_vld));
      check($sformatf("word_out nl%0d c%0d", nl, c), word_out, held_word);
      check($sformatf("cfg_err nl%0d c%0d", nl, c), 32'(cfg_err), 32'(exp_cfg));
      if (err) begin
        if (skew_err) begin skew_pulses++; skew_cyc = c; end
        if (packet_done_out) begin pdo_pulses++; pdo_cyc = c; end
      end else begin
        exp_pdo = (drop_at < 0) && (c == dmax + n + 1);
        check($sformatf("skew_err nl%0d c%0d", nl, c), 32'(skew_err), 32'd0);
        check($sformatf("pdo nl%0d c%0d", nl, c), 32'(packet_done_out), 32'(exp_pdo));
      end

      if (c == rst_at) begin
        #2;
        reset_n = 1'b0;
        #1;
        check("rst word_vld", 32'(word_vld), 32'd0);
        check("rst word_out", word_out, 32'd0);
        check("rst skew_err", 32'(skew_err), 32'd0);
        check("rst pdo", 32'(packet_done_out), 32'd0);
        check("rst cfg_err", 32'(cfg_err), 32'd0);
        held_word = '0;
        stop      = 1'b1;
        tick();
        reset_n = 1'b1;
      end else begin
        tick();
      end
    end

    byte_vld    = '0;
    packet_done = 1'b0;
    enable      = 1'b1;
    if (err) begin
      check($sformatf("skew_err pulses nl%0d", nl), 32'(skew_pulses), 32'd1);
      check($sformatf("pdo pulses nl%0d", nl), 32'(pdo_pulses), 32'd1);
      check($sformatf("err pulse align nl%0d", nl), 32'(skew_cyc), 32'(pdo_cyc));
    end
    tick();
    tick();
  endtask

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b0;
    num_lanes     = LCW'(4);
    wait_for_sync = 1'b0;
    packet_done   = 1'b0;
    byte_in       = '0;
    byte_vld      = '0;
    held_word     = '0;
    #12;
    reset_n = 1'b1;
    tick();
    @(negedge byte_clock);
    check("reset word_vld", 32'(word_vld), 32'd0);
    check("reset word_out", word_out, 32'd0);
    check("reset skew_err", 32'(skew_err), 32'd0);
    check("reset pdo", 32'(packet_done_out), 32'd0);
    check("reset cfg_err", 32'(cfg_err), 32'd0);
    tick();

    lane_delay = '{0, 0, 0, 0};
    run_packet(4, 6, -1, -1, 8'hB8);

    lane_delay = '{0, 0, 0, 3};
    run_packet(4, 8, -1, -1, -1);

    lane_delay = '{0, 0, 5, 0};
    run_packet(4, 8, -1, -1, -1);

    lane_delay = '{0, 1, 0, 0};
    run_packet(2, 7, -1, -1, -1);

    lane_delay = '{1, 0, 2, 0};
    run_packet(0, 6, -1, -1, -1);

    lane_delay = '{0, 2, 1, 0};
    run_packet(4, 2, -1, -1, -1);

    lane_delay = '{0, 0, 0, 0};
    run_packet(4, 10, -1, 5, -1);

    lane_delay = '{0, 1, 0, 0};
    run_packet(3, 10, 5, -1, -1);

    lane_delay = '{0, 0, 0, 0};
    run_packet(4, 4, -1, -1, -1);

    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < MAX_LANE; i++) lane_delay[i] = $urandom_range(0, 4);
      run_packet($urandom_range(0, 7), $urandom_range(2, 10),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
